// File: rtl/button_sync_array.sv
// button_sync_array: per-channel synchroniser, debouncer and auto-repeat press/release pulse generator
module button_sync_array #(
    parameter int N             = 4,
    parameter int ACTIVE_LOW    = 1,
    parameter int SYNC_STAGES   = 2,
    parameter int DEBOUNCE      = 4,
    parameter int REPEAT_DELAY  = 50,
    parameter int REPEAT_PERIOD = 10
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic [N-1:0] in_i,
    input  logic [N-1:0] repeat_en_i,
    output logic [N-1:0] pressed_o,
    output logic [N-1:0] press_o,
    output logic [N-1:0] release_o
);
    localparam int DW   = $clog2(DEBOUNCE + 1);
    localparam int RMAX = REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE - 1);
    localparam logic [RW-1:0] RD_END  = RW'(REPEAT_DELAY);
    localparam logic [RW-1:0] RP_END  = RW'(REPEAT_PERIOD);
    localparam logic [RW-1:0] R_ONE   = RW'(1);
    localparam logic [SYNC_STAGES-1:0] SYNC_IDLE = {SYNC_STAGES{ACTIVE_LOW != 0}};

    typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;

    for (genvar g = 0; g < N; g++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q;
        logic [DW-1:0]          db_q, db_d;
        logic [RW-1:0]          rc_q, rc_d;
        state_t                 st_q, st_d;
        logic                   pressed_q, pressed_d, press_q, press_d, release_q, release_d;
        logic                   act, accept;

        assign act          = sync_q[SYNC_STAGES-1] ^ (ACTIVE_LOW != 0);
        assign pressed_o[g] = pressed_q;
        assign press_o[g]   = press_q;
        assign release_o[g] = release_q;

        always_comb begin
            accept    = (act != pressed_q) && (db_q == DB_LAST);
            db_d      = (act == pressed_q || accept) ? '0 : db_q + 1'b1;
            pressed_d = pressed_q ^ accept;
            st_d      = st_q;
            rc_d      = rc_q;
            press_d   = 1'b0;
            release_d = 1'b0;
            if (accept && pressed_q) begin
                release_d = 1'b1;
                st_d      = IDLE;
                rc_d      = '0;
            end else if (accept) begin
                press_d = 1'b1;
                st_d    = DELAY;
                rc_d    = repeat_en_i[g] ? R_ONE : '0;
            end else if (st_q != IDLE) begin
                // disabling repeat parks in DELAY so re-enabling waits a full delay
                if (!repeat_en_i[g]) begin
                    st_d = DELAY;
                    rc_d = '0;
                end else if (rc_q == (st_q == DELAY ? RD_END : RP_END)) begin
                    press_d = 1'b1;
                    st_d    = REPEAT;
                    rc_d    = R_ONE;
                end else begin
                    rc_d = rc_q + 1'b1;
                end
            end
        end

        always_ff @(posedge clk_i or posedge reset_i) begin
            if (reset_i) begin
                sync_q    <= SYNC_IDLE;
                db_q      <= '0;
                rc_q      <= '0;
                st_q      <= IDLE;
                pressed_q <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
            end else begin
                sync_q    <= {sync_q[SYNC_STAGES-2:0], in_i[g]};
                db_q      <= db_d;
                rc_q      <= rc_d;
                st_q      <= st_d;
                pressed_q <= pressed_d;
                press_q   <= press_d;
                release_q <= release_d;
            end
        end
    end
endmodule

// File: tb/tb_button_sync_array.sv
// tb_button_sync_array: directed and randomised checks of button_sync_array against a timing-window model
module tb_button_sync_array;
    localparam int N = 4, AL = 1, SS = 2, D = 4, RD = 5, RP = 3, HMAX = 8192;

    logic         clk = 1'b0, reset = 1'b1;
    logic [N-1:0] in_r = '1, ren = '0;
    logic [N-1:0] pressed, press, rel;

    button_sync_array #(
        .N(N), .ACTIVE_LOW(AL), .SYNC_STAGES(SS), .DEBOUNCE(D),
        .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut (
        .clk_i(clk), .reset_i(reset), .in_i(in_r), .repeat_en_i(ren),
        .pressed_o(pressed), .press_o(press), .release_o(rel)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Model: edge t (since reset) sees the active level sampled SS edges earlier; the level
    // flips once D consecutive edges disagree with it; repeats are scheduled as due edges.
    int           t = 0;
    int           due [N];
    logic         acth [N][HMAX];
    logic [N-1:0] m_lvl = '0, m_p = '0, m_r = '0;

    function automatic logic act_at(input int c, input int u);
        return (u - SS >= 1) ? acth[c][u-SS] : 1'b0;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            t = 0; m_lvl = '0; m_p = '0; m_r = '0;
            for (int c = 0; c < N; c++) due[c] = -1;
        end else begin
            t++;
            for (int c = 0; c < N; c++) begin
                logic tog;
                acth[c][t] = AL ? !in_r[c] : in_r[c];
                tog = 1'b1;
                for (int k = 0; k < D; k++) if (act_at(c, t - k) == m_lvl[c]) tog = 1'b0;
                m_p[c] = 1'b0;
                m_r[c] = 1'b0;
                if (tog && m_lvl[c]) begin
                    m_r[c] = 1'b1; m_lvl[c] = 1'b0; due[c] = -1;
                end else if (tog) begin
                    m_p[c] = 1'b1; m_lvl[c] = 1'b1; due[c] = ren[c] ? t + RD : -1;
                end else if (m_lvl[c]) begin
                    if (!ren[c]) due[c] = -1;
                    else if (due[c] < 0) due[c] = t + RD;
                    else if (t == due[c]) begin m_p[c] = 1'b1; due[c] = t + RP; end
                end
            end
        end
    end

    always @(negedge clk) chk("model", {pressed, press, rel}, {m_lvl, m_p, m_r});

    initial begin
        int cnt, cnt2, k, p0;
        int q[$];
        int exp_off[5] = '{5, 8, 11, 14, 17};
        int off[N], pe[N];
        for (int c = 0; c < N; c++) due[c] = -1;
        repeat (3) step();
        chk("reset_state", {pressed, press, rel}, 0);

        reset = 1'b0;
        in_r[0] = 1'b0;
        for (int e = 1; e <= 20; e++) begin
            step();
            if (e >= 5 && e <= 7)
                chk($sformatf("clean_press_e%0d", e), {pressed[0], press[0], rel[0]},
                    e == 5 ? 3'b000 : e == 6 ? 3'b110 : 3'b100);
            if (e == 20) chk("clean_idle_ch123", {pressed[3:1], press[3:1], rel[3:1]}, 0);
        end

        in_r[1] = 1'b0;
        cnt = 0;
        for (int e = 1; e <= 12; e++) begin
            if (e == 4) in_r[1] = 1'b1;
            step();
            cnt += int'(pressed[1]) + int'(press[1]) + int'(rel[1]);
        end
        chk("glitch3", cnt, 0);
        in_r[1] = 1'b0;
        cnt = 0; cnt2 = 0;
        for (int e = 1; e <= 16; e++) begin
            if (e == 5) in_r[1] = 1'b1;
            step();
            cnt += int'(press[1]);
            cnt2 += int'(rel[1]);
        end
        chk("glitch4_press", cnt, 1);
        chk("glitch4_release", cnt2, 1);

        in_r[0] = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            step();
            if (e >= 5)
                chk($sformatf("release_e%0d", e), {pressed[0], press[0], rel[0]},
                    e == 5 ? 3'b100 : e == 6 ? 3'b001 : 3'b000);
        end

        ren[2] = 1'b1;
        in_r[2] = 1'b0;
        k = 0;
        do begin step(); k++; end while (!press[2] && k < 20);
        chk("rpt_first_latency", k, 6);
        for (int e = 1; e <= 19; e++) begin
            step();
            if (press[2]) q.push_back(e);
        end
        chk("rpt_count", q.size(), 5);
        for (int i = 0; i < 5 && i < q.size(); i++) chk($sformatf("rpt_offset%0d", i), q[i], exp_off[i]);

        ren[2] = 1'b0;
        cnt = 0;
        for (int e = 1; e <= 10; e++) begin step(); cnt += int'(press[2]); end
        chk("rpt_disabled", cnt, 0);
        ren[2] = 1'b1;
        k = 0;
        do begin step(); k++; end while (!press[2] && k < 12);
        chk("rpt_reenable", k, RD + 1);

        in_r[2] = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            step();
            if (e == 3) chk("rpt_before_rel", press[2], 1);
            if (e == 6) chk("release_wins", {pressed[2], press[2], rel[2]}, 3'b001);
        end

        ren = '0;
        repeat (10) step();
        chk("all_released", pressed, 0);
        for (int c = 0; c < N; c++) begin off[c] = $urandom_range(2, 5); pe[c] = -1; end
        for (int e = 0; e <= 16; e++) begin
            for (int c = 0; c < N; c++) if (e == off[c]) in_r[c] = 1'b0;
            step();
            for (int c = 0; c < N; c++) if (press[c]) pe[c] = e + 1;
        end
        for (int c = 0; c < N; c++) chk($sformatf("simul_ch%0d", c), pe[c], off[c] + 6);

        step();
        #3 reset = 1'b1;
        #1 chk("reset_async", {pressed, press, rel}, 0);
        repeat (2) step();
        reset = 1'b0;
        cnt = 0;
        for (int e = 1; e <= 7; e++) begin
            step();
            cnt += int'(|rel);
            if (e == 5) chk("rehold_e5", press, 0);
            if (e == 6) chk("rehold_press", {pressed, press}, {4'hF, 4'hF});
        end
        chk("rehold_no_release", cnt, 0);

        for (int i = 0; i < 2000; i++) begin
            for (int c = 0; c < N; c++) begin
                if ($urandom_range(0, 29) == 0) in_r[c] = ~in_r[c];
                if ($urandom_range(0, 59) == 0) ren[c] = ~ren[c];
            end
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
